// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract: N-bit operands processed C bits per cycle, LSB chunk first,
// with optional signed saturation and valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | accepting operands, in_ready=1
// RUN   | one chunk per cycle, carry rippled between chunks
// DONE  | result presented, held until out_ready
module seq_addsub #(
    parameter int N = 16,
    parameter int C = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic         sat,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         CF,
    output logic         OF
);
    localparam int NCH = N / C;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    if (N % C != 0) begin : g_bad_cfg
        $error("seq_addsub: N must be a multiple of C");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   a_q, d_q, s_q, s_upd, s_fin;
    logic           carry_q, sat_q, cf_q, of_q;
    logic [CW-1:0]  cnt;
    logic [C:0]     chunk_sum;
    logic           last_chunk, of_w;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Current chunk sum, with the result word patched in place; OF and
    // saturation only matter once the MSB chunk has been written.
    always_comb begin
        last_chunk = (cnt == CW'(NCH - 1));
        chunk_sum  = {1'b0, a_q[int'(cnt)*C +: C]} + {1'b0, d_q[int'(cnt)*C +: C]}
                   + {{C{1'b0}}, carry_q};
        s_upd = s_q;
        s_upd[int'(cnt)*C +: C] = chunk_sum[C-1:0];
        of_w  = (~s_upd[N-1] &  a_q[N-1] &  d_q[N-1])
              | ( s_upd[N-1] & ~a_q[N-1] & ~d_q[N-1]);
        s_fin = s_upd;
        if (sat_q && of_w)
            s_fin = a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            d_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        d_q     <= B ^ {N{sub}};
                        carry_q <= sub;
                        sat_q   <= sat;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    carry_q <= chunk_sum[C];
                    cnt     <= cnt + CW'(1);
                    if (last_chunk) begin
                        s_q  <= s_fin;
                        cf_q <= chunk_sum[C];
                        of_q <= of_w;
                    end else begin
                        s_q  <= s_upd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign S         = s_q;
    assign CF        = cf_q;
    assign OF        = of_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub (N=16, C=4): table vectors and random ops through a scoreboard,
// plus hand sequences for output stall, mid-operation reset and back-to-back throughput.
module tb_seq_addsub;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, sub, sat, out_valid, out_ready, CF, OF;
    logic [15:0] A, B, S;

    typedef struct {
        logic [15:0] a, b;
        logic        sub, sat;
        logic [15:0] s;
        logic        cf, of;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    seq_addsub #(.N(16), .C(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sub(sub), .sat(sat), .A(A), .B(B), .out_valid(out_valid),
        .out_ready(out_ready), .S(S), .CF(CF), .OF(OF)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model(input logic [15:0] a, b, input logic su, sa);
        vec_t        v;
        logic [15:0] d;
        logic [16:0] full;
        d    = su ? ~b : b;
        full = {1'b0, a} + {1'b0, d} + {16'd0, su};
        v.a = a; v.b = b; v.sub = su; v.sat = sa;
        v.s  = full[15:0];
        v.cf = full[16];
        v.of = (a[15] == d[15]) && (full[15] != a[15]);
        if (sa && v.of) v.s = a[15] ? 16'h8000 : 16'h7FFF;
        return v;
    endfunction

    // Scoreboard: every completed output handshake is matched against the oldest accepted op.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(S), 32'hFFFF_FFFF);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("S",  32'(S),  32'(e.s));
                check("CF", 32'(CF), 32'(e.cf));
                check("OF", 32'(OF), 32'(e.of));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input int hold);
        int cyc;
        check("in_ready_before_op", 32'(in_ready), 32'd1);
        A = v.a; B = v.b; sub = v.sub; sat = v.sat;
        in_valid = 1'b1; out_ready = 1'b0;
        sb.push_back(v);
        tick();
        in_valid = 1'b0;
        A = 16'($urandom); B = 16'($urandom); sub = ~sub; sat = ~sat;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'd4);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            A = 16'($urandom); B = 16'($urandom);
            tick();
            check("hold_S",        32'(S),         32'(v.s));
            check("hold_CF",       32'(CF),        32'(v.cf));
            check("hold_OF",       32'(OF),        32'(v.of));
            check("hold_in_ready", 32'(in_ready),  32'd0);
            check("hold_valid",    32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready",  32'(in_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   iters, ov, b2b_acc;
        vec_t v;

        vecs[0] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
        vecs[7] = '{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sub = 1'b0; sat = 1'b0; A = 16'h0; B = 16'h0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_S",         32'(S),         32'd0);
        check("rst_CF",        32'(CF),        32'd0);
        check("rst_OF",        32'(OF),        32'd0);

        for (int i = 0; i < 8; i++) run_op(vecs[i], (i == 0) ? 5 : (i % 2));

        for (int i = 0; i < 8; i++) begin
            run_op(model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)), 0);
        end

        // Abort during the second RUN cycle; the pending op must never appear.
        A = 16'hAAAA; B = 16'h5555; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_S",         32'(S),         32'd0);
        check("abort_CF",        32'(CF),        32'd0);
        check("abort_OF",        32'(OF),        32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        run_op('{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0}, 0);

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        b2b_acc   = 0;
        for (int k = 0; k < 3; k++) begin
            v = model(16'(16'h1000 * (k + 1) + 16'h0F0F), 16'(16'h0123 * (k + 3)), 1'(k), 1'b0);
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            A = v.a; B = v.b; sub = v.sub; sat = v.sat;
            sb.push_back(v);
            b2b_acc++;
            tick();
            iters = 0; ov = 0;
            while (!in_ready && iters < 20) begin
                tick();
                iters++;
                if (out_valid) ov++;
            end
            if (k == 2) in_valid = 1'b0;
            check("b2b_spacing",     32'(iters + 1), 32'd6);
            check("b2b_valid_pulse", 32'(ov),        32'd1);
        end
        tick();
        out_ready = 1'b0;
        check("b2b_idle",     32'(in_ready), 32'd1);
        check("sb_drained",   32'(sb.size()), 32'd0);
        check("b2b_accepted", 32'(b2b_acc),  32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
